mr_ntt_ctrl: RTL

MR_NTT_CTRL -- requirements
Module: mr_ntt_ctrl

---
 rtl/mr_ntt_ctrl_if.sv | 23 ++
 rtl/mr_ntt_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mr_ntt_ctrl_if.sv
// Handshake and sequencing bus between the NTT controller and its datapath.
interface mr_ntt_ctrl_if #(parameter int LOGN = 8);
  logic            start;
  logic            busy;
  logic            done;
  logic            sel;
  logic            sen;
  logic            ien;
  logic [2:0]      stage;
  logic            rd_valid;
  logic [LOGN-3:0] rd_idx;
  logic            wr_valid;
  logic [LOGN-3:0] wr_idx;
  logic [LOGN:0]   tw_addr;

  modport master (output start,
                  input  busy, done, sel, sen, ien, stage,
                  input  rd_valid, rd_idx, wr_valid, wr_idx, tw_addr);

  modport slave  (input  start,
                  output busy, done, sel, sen, ien, stage,
                  output rd_valid, rd_idx, wr_valid, wr_idx, tw_addr);
endinterface

// File: rtl/mr_ntt_ctrl.sv
// Stage/group sequencer for a mixed radix-4 / radix-2 NTT butterfly unit.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing one operand-group read per clock
//   FLUSH | PE_LAT-cycle drain so the next stage never reads stale data
//   DONE  | one-cycle completion pulse
module mr_ntt_ctrl #(
  parameter int LOGN   = 8,
  parameter int PE_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  mr_ntt_ctrl_if.slave  bus
);
  localparam int   IW    = LOGN - 2;
  localparam int   S     = (LOGN + 1) / 2;
  localparam int   G     = 1 << IW;
  localparam int   FW    = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic ODD   = (LOGN % 2) == 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              cnt_q, cnt_d;
  logic [2:0]                 stage_q, stage_d;
  logic [FW-1:0]              fl_q, fl_d;
  logic [LOGN:0]              tw_q, tw_d;
  logic [PE_LAT-1:0]          pv_q, pv_d;
  logic [PE_LAT-1:0][IW-1:0]  pi_q, pi_d;

  logic          run_c, act_c, r4_c;
  logic [LOGN:0] tw_run_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      fl_q    <= '0;
      tw_q    <= '0;
      pv_q    <= '0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      fl_q    <= fl_d;
      tw_q    <= tw_d;
      pv_q    <= pv_d;
      pi_q    <= pi_d;
    end
  end

  // cnt wraps to 0 naturally after G-1 because G is a power of two
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    fl_d    = fl_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        fl_d  = '0;
        if (cnt_q == IW'(G - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        fl_d = fl_q + 1'b1;
        if (fl_q == FW'(PE_LAT - 1)) begin
          if (stage_q == 3'(S - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            cnt_d   = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // stage*G + cnt is a plain concatenation since G = 2^IW
  always_comb begin
    run_c    = (state_q == RUN);
    act_c    = run_c || (state_q == FLUSH);
    r4_c     = !(ODD && (stage_q == 3'(S - 1)));
    tw_run_c = {stage_q, cnt_q};
    tw_d     = run_c ? tw_run_c : tw_q;
    pv_d     = '0;
    pi_d     = '0;
    pv_d[0]  = run_c;
    pi_d[0]  = cnt_q;
    for (int i = 1; i < PE_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
  end

  assign bus.busy     = act_c;
  assign bus.done     = (state_q == DONE);
  assign bus.sel      = act_c && r4_c;
  assign bus.ien      = act_c && r4_c;
  assign bus.sen      = act_c && !r4_c;
  assign bus.stage    = stage_q;
  assign bus.rd_valid = run_c;
  assign bus.rd_idx   = cnt_q;
  assign bus.wr_valid = pv_q[PE_LAT-1];
  assign bus.wr_idx   = pi_q[PE_LAT-1];
  assign bus.tw_addr  = run_c ? tw_run_c : tw_q;
endmodule
